// File: rtl/icache_pkg.sv
// Shared defaults, word width and refill-state encoding
// for the instruction-cache data array.
package icache_pkg;

   localparam int WORD_W = 32;

   localparam int DEF_WAYS = 2;
   localparam int DEF_SETS = 128;
   localparam int DEF_LINE_WORDS = 8;
   localparam int DEF_FETCH_WORDS = 2;
   localparam int DEF_BEAT_WORDS = 2;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE
   } rf_state_e;

endpackage

// File: rtl/icache_data_bank.sv
// One cache way: simple dual-port RAM, registered read,
// whole-line write.
module icache_data_bank
   import icache_pkg::*;
#(
   parameter int SETS = DEF_SETS,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(SETS)-1:0]      waddr,
   input  logic [WORD_W*LINE_WORDS-1:0] wdata,
   input  logic                         re,
   input  logic [$clog2(SETS)-1:0]      raddr,
   output logic [WORD_W*LINE_WORDS-1:0] rdata
);

   logic [WORD_W*LINE_WORDS-1:0] mem [SETS];

   // Same-address read/write returns the old line.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/icache_data_array.sv
// I-cache data array: N-way banks, fetch read port, beat refill.
// ICACHE_DATA_BYPASS_EN: serve reads of the set being written.
module icache_data_array
   import icache_pkg::*;
#(
   parameter int WAYS = DEF_WAYS,
   parameter int SETS = DEF_SETS,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int FETCH_WORDS = DEF_FETCH_WORDS,
   parameter int BEAT_WORDS = DEF_BEAT_WORDS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rd_req,
   output logic                          rd_ready,
   input  logic [$clog2(SETS)-1:0]       rd_index,
   input  logic [$clog2(LINE_WORDS)+1:0] rd_offset,
   input  logic [WAYS-1:0]               rd_hit_way,
   output logic                          rd_valid,
   output logic [WORD_W*FETCH_WORDS-1:0] rd_data,
   output logic [FETCH_WORDS-1:0]        rd_word_valid,
   input  logic                          rf_start,
   input  logic [$clog2(SETS)-1:0]       rf_index,
   input  logic [$clog2(WAYS)-1:0]       rf_way,
   input  logic                          rf_beat_valid,
   input  logic [WORD_W*BEAT_WORDS-1:0]  rf_beat_data,
   input  logic                          rf_beat_last,
   output logic                          rf_busy,
   output logic                          rf_done,
   output logic                          rf_err
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WI_W = $clog2(LINE_WORDS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int LINE_W = WORD_W * LINE_WORDS;
   localparam int BEAT_W = WORD_W * BEAT_WORDS;
   localparam int NBEATS = LINE_WORDS / BEAT_WORDS;
   localparam int CNT_W = $clog2(NBEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   rf_state_e         state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              err_nx;
   logic [IDX_W-1:0]  rf_idx_q;
   logic [WAY_W-1:0]  rf_way_q;
   logic [LINE_W-1:0] fill_buf;
   logic              rd_accept;
   logic [WI_W-1:0]   word_q;
   logic [LINE_W-1:0] bank_q [WAYS];
   logic [LINE_W-1:0] way_line [WAYS];
   logic [LINE_W-1:0] line_sel;
   logic              unused_ok;

   assign unused_ok = ^rd_offset[1:0];

   assign rf_busy = (state != IDLE);
   assign rf_done = (state == WRITE);

   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      err_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (rf_start) begin
               state_nx = FILL;
               cnt_nx = '0;
            end
         end
         FILL: begin
            if (rf_beat_valid) begin
               if ((cnt == LAST_BEAT) != rf_beat_last) begin
                  state_nx = IDLE;
                  err_nx = 1'b1;
                  cnt_nx = '0;
               end else if (rf_beat_last) begin
                  state_nx = WRITE;
                  cnt_nx = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
         end
         WRITE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      rd_ready = 1'b1;
`ifndef ICACHE_DATA_BYPASS_EN
      if (state == WRITE && rd_index == rf_idx_q)
         rd_ready = 1'b0;
`endif
   end

   assign rd_accept = rd_req && rd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rf_err <= 1'b0;
         rf_idx_q <= '0;
         rf_way_q <= '0;
         rd_valid <= 1'b0;
         word_q <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         rf_err <= err_nx;
         rd_valid <= rd_accept;
         if (state == IDLE && rf_start) begin
            rf_idx_q <= rf_index;
            rf_way_q <= rf_way;
         end
         if (rd_accept) word_q <= rd_offset[WI_W+1:2];
      end
   end

   always_ff @(posedge clk) begin
      if (state == FILL && rf_beat_valid)
         fill_buf[int'(cnt)*BEAT_W +: BEAT_W] <= rf_beat_data;
   end

`ifdef ICACHE_DATA_BYPASS_EN
   logic             byp_q;
   logic [WAY_W-1:0] byp_way_q;

   // fill_buf cannot change before the read returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byp_q <= 1'b0;
         byp_way_q <= '0;
      end else begin
         byp_q <= rd_accept && state == WRITE
                  && rd_index == rf_idx_q;
         byp_way_q <= rf_way_q;
      end
   end
`endif

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_data_bank #(
         .SETS(SETS),
         .LINE_WORDS(LINE_WORDS)
      ) u_bank (
         .clk(clk),
         .we(state == WRITE && rf_way_q == WAY_W'(w)),
         .waddr(rf_idx_q),
         .wdata(fill_buf),
         .re(rd_accept),
         .raddr(rd_index),
         .rdata(bank_q[w])
      );
`ifdef ICACHE_DATA_BYPASS_EN
      assign way_line[w] =
         (byp_q && byp_way_q == WAY_W'(w)) ? fill_buf : bank_q[w];
`else
      assign way_line[w] = bank_q[w];
`endif
   end

   always_comb begin
      line_sel = '0;
      for (int w = 0; w < WAYS; w++)
         if (rd_hit_way[w]) line_sel = line_sel | way_line[w];
   end

   // Words past the line end read as zero, no wrap.
   always_comb begin
      rd_data = '0;
      rd_word_valid = '0;
      for (int k = 0; k < FETCH_WORDS; k++) begin
         if (int'(word_q) + k < LINE_WORDS) begin
            rd_word_valid[k] = rd_valid;
            rd_data[k*WORD_W +: WORD_W] =
               line_sel[(int'(word_q) + k)*WORD_W +: WORD_W];
         end
      end
   end

endmodule

// File: tb/tb_icache_data_array.sv
// Directed-vector bench for icache_data_array (default params).
module tb_icache_data_array;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req;
   logic        rd_ready;
   logic [6:0]  rd_index;
   logic [4:0]  rd_offset;
   logic [1:0]  rd_hit_way;
   logic        rd_valid;
   logic [63:0] rd_data;
   logic [1:0]  rd_word_valid;
   logic        rf_start;
   logic [6:0]  rf_index;
   logic [0:0]  rf_way;
   logic        rf_beat_valid;
   logic [63:0] rf_beat_data;
   logic        rf_beat_last;
   logic        rf_busy;
   logic        rf_done;
   logic        rf_err;

   int n_vec = 0;
   int n_err = 0;

   icache_data_array dut (
      .clk(clk),
      .rst(rst),
      .rd_req(rd_req),
      .rd_ready(rd_ready),
      .rd_index(rd_index),
      .rd_offset(rd_offset),
      .rd_hit_way(rd_hit_way),
      .rd_valid(rd_valid),
      .rd_data(rd_data),
      .rd_word_valid(rd_word_valid),
      .rf_start(rf_start),
      .rf_index(rf_index),
      .rf_way(rf_way),
      .rf_beat_valid(rf_beat_valid),
      .rf_beat_data(rf_beat_data),
      .rf_beat_last(rf_beat_last),
      .rf_busy(rf_busy),
      .rf_done(rf_done),
      .rf_err(rf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, want finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      int          idx;
      int          off;
      logic [1:0]  hit;
      logic [63:0] d;
      logic [1:0]  wv;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [63:0] pair(input int hi, input int lo);
      return {32'(hi), 32'(lo)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic rd(input string nm, input int idx, input int off,
                     input logic [1:0] hit, input logic [63:0] exd,
                     input logic [1:0] exv);
      rd_req = 1'b1;
      rd_index = 7'(idx);
      rd_offset = 5'(off);
      #1;
      chk({nm, "/ready"}, 64'(rd_ready), 64'd1);
      tick();
      rd_req = 1'b0;
      rd_hit_way = hit;
      #1;
      chk({nm, "/valid"}, 64'(rd_valid), 64'd1);
      chk({nm, "/data"}, rd_data, exd);
      chk({nm, "/wv"}, 64'(rd_word_valid), 64'(exv));
      tick();
      chk({nm, "/valid_drop"}, 64'(rd_valid), 64'd0);
   endtask

   // Line word i of the refilled line is base+i.
   task automatic refill(input int idx, input int way, input int base,
                         input bit stop_in_write);
      rf_start = 1'b1;
      rf_index = 7'(idx);
      rf_way = 1'(way);
      tick();
      rf_start = 1'b0;
      chk("refill/busy", 64'(rf_busy), 64'd1);
      for (int k = 0; k < 4; k++) begin
         rf_beat_valid = 1'b1;
         rf_beat_data = pair(base + 2*k + 1, base + 2*k);
         rf_beat_last = (k == 3);
         tick();
      end
      rf_beat_valid = 1'b0;
      rf_beat_last = 1'b0;
      chk("refill/done", 64'(rf_done), 64'd1);
      if (!stop_in_write) begin
         tick();
         chk("refill/idle", 64'(rf_busy), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1;
      rd_req = 1'b0;
      rd_index = '0;
      rd_offset = '0;
      rd_hit_way = '0;
      rf_start = 1'b0;
      rf_index = '0;
      rf_way = '0;
      rf_beat_valid = 1'b0;
      rf_beat_data = '0;
      rf_beat_last = 1'b0;

      tbl[0] = '{5, 'h08, 2'b10, pair(3, 2), 2'b11};
      tbl[1] = '{5, 'h1C, 2'b10, pair(0, 7), 2'b01};
      tbl[2] = '{5, 'h00, 2'b01, pair(101, 100), 2'b11};
      tbl[3] = '{5, 'h14, 2'b01, pair(106, 105), 2'b11};
      tbl[4] = '{5, 'h18, 2'b10, pair(7, 6), 2'b11};
      tbl[5] = '{5, 'h04, 2'b10, pair(2, 1), 2'b11};
      tbl[6] = '{9, 'h0C, 2'b10, pair(204, 203), 2'b11};
      tbl[7] = '{5, 'h08, 2'b00, 64'd0, 2'b11};
      tbl[8] = '{5, 'h1C, 2'b01, pair(0, 107), 2'b01};
      tbl[9] = '{5, 'h0B, 2'b10, pair(3, 2), 2'b11};

      #1;
      chk("rst/busy", 64'(rf_busy), 64'd0);
      chk("rst/done", 64'(rf_done), 64'd0);
      chk("rst/err", 64'(rf_err), 64'd0);
      chk("rst/ready", 64'(rd_ready), 64'd1);
      chk("rst/valid", 64'(rd_valid), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Set 5 way 1, words 0..7; stray rf_start mid-fill ignored.
      rf_start = 1'b1;
      rf_index = 7'd5;
      rf_way = 1'b1;
      tick();
      rf_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("fill/busy", 64'(rf_busy), 64'd1);
         chk("fill/done_low", 64'(rf_done), 64'd0);
         rf_start = (k == 1);
         rf_index = (k == 1) ? 7'd9 : 7'd5;
         rf_beat_valid = 1'b1;
         rf_beat_data = pair(2*k + 1, 2*k);
         rf_beat_last = (k == 3);
         tick();
      end
      rf_start = 1'b0;
      rf_beat_valid = 1'b0;
      rf_beat_last = 1'b0;
      chk("write/done", 64'(rf_done), 64'd1);
      chk("write/busy", 64'(rf_busy), 64'd1);
      tick();
      chk("after/done", 64'(rf_done), 64'd0);
      chk("after/busy", 64'(rf_busy), 64'd0);

      refill(5, 0, 100, 1'b0);
      refill(9, 1, 200, 1'b0);

      for (int i = 0; i < 10; i++)
         rd($sformatf("vec%0d", i), tbl[i].idx, tbl[i].off,
            tbl[i].hit, tbl[i].d, tbl[i].wv);

      // Early last: error, no write.
      rf_start = 1'b1;
      rf_index = 7'd5;
      rf_way = 1'b1;
      tick();
      rf_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rf_beat_valid = 1'b1;
         rf_beat_data = pair('hBAD0 + k, 'hBAD8 + k);
         rf_beat_last = (k == 1);
         tick();
      end
      rf_beat_valid = 1'b0;
      rf_beat_last = 1'b0;
      chk("early/err", 64'(rf_err), 64'd1);
      chk("early/busy", 64'(rf_busy), 64'd0);
      chk("early/done", 64'(rf_done), 64'd0);
      tick();
      chk("early/err_drop", 64'(rf_err), 64'd0);
      rd("early/keep", 5, 'h00, 2'b10, pair(1, 0), 2'b11);

      // Final beat without last: error, no write.
      rf_start = 1'b1;
      tick();
      rf_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rf_beat_valid = 1'b1;
         rf_beat_data = pair('hEE00 + k, 'hEE10 + k);
         rf_beat_last = 1'b0;
         tick();
      end
      rf_beat_valid = 1'b0;
      chk("nolast/err", 64'(rf_err), 64'd1);
      chk("nolast/busy", 64'(rf_busy), 64'd0);
      chk("nolast/done", 64'(rf_done), 64'd0);
      tick();
      rd("nolast/keep", 5, 'h18, 2'b10, pair(7, 6), 2'b11);

      // Read of set 5 during its WRITE cycle.
      refill(5, 1, 'h50, 1'b1);
      rd_index = 7'd9;
      #1;
      chk("wr/other_ready", 64'(rd_ready), 64'd1);
      rd_req = 1'b1;
      rd_index = 7'd5;
      rd_offset = 5'h00;
      #1;
`ifdef ICACHE_DATA_BYPASS_EN
      chk("wr/ready", 64'(rd_ready), 64'd1);
      tick();
`else
      chk("wr/ready", 64'(rd_ready), 64'd0);
      tick();
      chk("wr/stall_valid", 64'(rd_valid), 64'd0);
      chk("wr/ready_next", 64'(rd_ready), 64'd1);
      tick();
`endif
      rd_req = 1'b0;
      rd_hit_way = 2'b10;
      #1;
      chk("wr/valid", 64'(rd_valid), 64'd1);
      chk("wr/data", rd_data, pair('h51, 'h50));
      tick();
      rd("wr/way0", 5, 'h00, 2'b01, pair(101, 100), 2'b11);

      // Reset mid-fill aborts set 5 way 0 refill.
      rf_start = 1'b1;
      rf_index = 7'd5;
      rf_way = 1'b0;
      tick();
      rf_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rf_beat_valid = 1'b1;
         rf_beat_data = pair('hAB00 + k, 'hAB10 + k);
         tick();
      end
      rf_beat_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort/busy", 64'(rf_busy), 64'd0);
      chk("abort/done", 64'(rf_done), 64'd0);
      chk("abort/ready", 64'(rd_ready), 64'd1);
      chk("abort/valid", 64'(rd_valid), 64'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort/no_done", 64'(rf_done), 64'd0);
      end
      rd("abort/keep", 5, 'h00, 2'b01, pair(101, 100), 2'b11);
      refill(9, 0, 'h300, 1'b0);
      rd("abort/new", 9, 'h10, 2'b01, pair('h305, 'h304), 2'b11);
      rd("abort/w1", 9, 'h0C, 2'b10, pair(204, 203), 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/icache_data_array.md
ICACHE_DATA_ARRAY -- requirements
Module: icache_data_array

Interface
REQ-001 SHALL have parameter WAYS, default 2: number of ways, power of 2.
REQ-002 SHALL have parameter SETS, default 128: sets per way, power of 2.
REQ-003 SHALL have parameter LINE_WORDS, default 8: 32-bit words per line, power of 2.
REQ-004 SHALL have parameter FETCH_WORDS, default 2: words per fetch, 1..LINE_WORDS.
REQ-005 SHALL have parameter BEAT_WORDS, default 2: words per refill beat, divides LINE_WORDS.
REQ-006 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have read ports: rd_req in 1; rd_ready out 1; rd_index in log2(SETS); rd_offset in log2(LINE_WORDS)+2 (byte offset); rd_hit_way in WAYS, one-hot, sampled one cycle after acceptance; rd_valid out 1; rd_data out 32*FETCH_WORDS; rd_word_valid out FETCH_WORDS.
REQ-008 SHALL have refill ports: rf_start in 1; rf_index in log2(SETS); rf_way in log2(WAYS); rf_beat_valid in 1; rf_beat_data in 32*BEAT_WORDS; rf_beat_last in 1; rf_busy out 1; rf_done out 1; rf_err out 1.

Function
REQ-009 SHALL accept a read when rd_req && rd_ready at the rising edge (cycle T).
REQ-010 SHALL assert rd_valid in T+1 only, with rd_data muxed from all ways by rd_hit_way (latency 1, no back-pressure).
REQ-011 SHALL set fetch word k = line word (rd_offset[..:2]+k); rd_word_valid[k]=1 only if that index < LINE_WORDS; invalid words read 0 (no wrap to word 0).
REQ-012 SHALL drive rd_data to 0 when rd_hit_way is all-zero; multi-hot is a protocol error, output undefined.
REQ-013 SHALL run refill FSM IDLE -> FILL (rf_start; latch rf_index/rf_way, beat count 0) -> WRITE (beat count reaches LINE_WORDS/BEAT_WORDS with rf_beat_last) -> IDLE.
REQ-014 SHALL store beat i (rf_beat_valid in FILL) into fill-buffer words i*BEAT_WORDS..i*BEAT_WORDS+BEAT_WORDS-1, lowest word in LSBs.
REQ-015 SHALL write the full line to the latched set/way in the single WRITE cycle and pulse rf_done that cycle.
REQ-016 SHALL, if rf_beat_last arrives before the final beat or the final beat arrives without rf_beat_last, pulse rf_err, return to IDLE, and perform no array write.
REQ-017 SHALL assert rf_busy in FILL and WRITE; rf_start in those states is ignored.
REQ-018 SHALL ignore rf_beat_valid in IDLE and WRITE.
REQ-019 SHALL keep rd_ready=1 in IDLE and FILL; read and line write may coincide on different sets.

Reset
REQ-020 SHALL, on rst assertion, immediately force IDLE, beat count 0, rd_valid=0, rf_busy=0, rf_done=0, rf_err=0, rd_ready=1.
REQ-021 SHALL abort a refill in progress on reset without any array write; array contents not reset.

Configuration
REQ-022 Macro ICACHE_DATA_BYPASS_EN defined: in WRITE, rd_ready stays 1; a read on the set being written returns fill-buffer data for way rf_way and array data for other ways.
REQ-023 Macro undefined: in WRITE, rd_ready=0 when rd_index equals the latched refill set, else 1.

Structure
REQ-024 SHALL place default parameters, FSM state typedef (IDLE/FILL/WRITE), and word-width constant in shared package icache_pkg.
REQ-025 SHALL implement each way as sub-module icache_data_bank: simple dual-port, 1-cycle-read, full-line-write RAM, SETS x 32*LINE_WORDS.

Verification
REQ-026 Refill set 5 way 1 with 4 beats of {2k+1,2k}, last on beat 4 -> rf_done pulse in WRITE cycle; read index 5 offset 0x08 hit 2'b10 -> rd_data={3,2}, word_valid 2'b11 at T+1.
REQ-027 Read offset 0x1C of that line -> rd_word_valid=2'b01, rd_data={0,7}.
REQ-028 rf_beat_last on beat 2 -> rf_err pulse, state IDLE, subsequent read of target line returns prior contents.
REQ-029 Read of set 5 issued in WRITE cycle: with macro -> accepted, returns new line; without -> rd_ready=0 that cycle, accepted next cycle, returns new line.
REQ-030 rst asserted mid-FILL (after beat 2) -> rf_busy=0 same cycle, no write, rf_done never pulses; new rf_start afterward completes normally.
REQ-031 rd_hit_way=2'b00 -> rd_valid=1, rd_data=0.
